instr_fetch: RTL

Instruction fetch stage sitting directly upstream of the execute stage. Holds the program counter and reads 16-bit instructions from the program ROM over a req/ack handshake. Presents each instruction on `order` with a valid/ready handshake toward execute. Supports jump redirect and a halt opcode.

---
 rtl/instr_fetch.sv | 121 ++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: holds the PC, reads 16-bit instructions from the program ROM, issues them to execute.
// Latency: run->mem_req 1 cycle, mem_ack->order/order_valid 1 cycle; best case one instruction per 2 cycles.
// Backpressure: order/order_valid held in ISSUE until exec_ready; a ROM read in flight always completes before issue.
//
// Ports: clk/rst_n (sync, active-low), run (fetch enable), mem_addr/mem_req/mem_ack/mem_rdata (ROM handshake),
//        order/order_valid/exec_ready (issue handshake), jump_en/jump_addr (redirect on accept), pc, halted.
// Optional build macro FETCH_SINGLE_STEP_EN adds a `step` input: one instruction fetched per step rising edge.
module instr_fetch #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [3:0]      HALT_OP  = 4'b1111
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
`ifdef FETCH_SINGLE_STEP_EN
    input  logic            step,
`endif
    output logic [PC_W-1:0] mem_addr,
    output logic            mem_req,
    input  logic            mem_ack,
    input  logic [15:0]     mem_rdata,
    output logic [15:0]     order,
    output logic            order_valid,
    input  logic            exec_ready,
    input  logic            jump_en,
    input  logic [PC_W-1:0] jump_addr,
    output logic [PC_W-1:0] pc,
    output logic            halted
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     order_q, order_d;
    logic            mem_req_q, mem_req_d;
    logic            order_valid_q, order_valid_d;
    logic            halted_q, halted_d;
    logic            go;

`ifdef FETCH_SINGLE_STEP_EN
    // Step edge is only consumed where a fetch may start; elsewhere it is simply lost.
    logic step_q, step_d;
    assign step_d = step;
    assign go     = run & step & ~step_q;
`else
    assign go     = run;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        order_d = order_q;
        case (state_q)
            IDLE: begin
                if (go) state_d = FETCH;
            end
            FETCH: begin
                // run is deliberately ignored here: the outstanding read must finish.
                if (mem_ack) begin
                    order_d = mem_rdata;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (exec_ready) begin
                    if (order_q[15:12] == HALT_OP) begin
                        state_d = HALT;
                    end else begin
                        pc_d    = jump_en ? jump_addr : pc_q + PC_W'(1);
                        state_d = go ? FETCH : IDLE;
                    end
                end
            end
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
        // Outputs are registered from the next state so they line up with state_q.
        mem_req_d     = (state_d == FETCH);
        order_valid_d = (state_d == ISSUE);
        halted_d      = (state_d == HALT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            order_q       <= 16'h0000;
            mem_req_q     <= 1'b0;
            order_valid_q <= 1'b0;
            halted_q      <= 1'b0;
`ifdef FETCH_SINGLE_STEP_EN
            step_q        <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            order_q       <= order_d;
            mem_req_q     <= mem_req_d;
            order_valid_q <= order_valid_d;
            halted_q      <= halted_d;
`ifdef FETCH_SINGLE_STEP_EN
            step_q        <= step_d;
`endif
        end
    end

    assign pc          = pc_q;
    assign mem_addr    = pc_q;
    assign order       = order_q;
    assign mem_req     = mem_req_q;
    assign order_valid = order_valid_q;
    assign halted      = halted_q;

endmodule
